mips_multi_control: RTL and testbench

//  Multicycle MIPS main control FSM. Sequences the shared datapath: memory, IR, ALU, PC and
//  the register file write port (reg_write, reg_dst, mem_to_reg select Write_Register_1/Write_Data).

---
 rtl/mips_ctrl_pkg.sv | 63 ++++++
 rtl/mips_ctrl_decode.sv | 85 ++++++++
 rtl/mips_multi_control.sv | 84 ++++++++
 tb/tb_mips_multi_control.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS control FSM: opcodes, states, datapath selects
// and the packed control vector passed from the decoder to the top.
package mips_ctrl_pkg;

    localparam int OPCODE_W = 6;
    localparam int STATE_W  = 4;

    localparam logic [OPCODE_W-1:0] OP_RTYPE = 6'b000000;
    localparam logic [OPCODE_W-1:0] OP_LW    = 6'b100011;
    localparam logic [OPCODE_W-1:0] OP_SW    = 6'b101011;
    localparam logic [OPCODE_W-1:0] OP_BEQ   = 6'b000100;
    localparam logic [OPCODE_W-1:0] OP_ADDI  = 6'b001000;
    localparam logic [OPCODE_W-1:0] OP_J     = 6'b000010;

    typedef enum logic [STATE_W-1:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,
        S_ADDIEX = 4'd9,
        S_ADDIWB = 4'd10,
        S_JUMP   = 4'd11
    } state_t;

    localparam logic [1:0] ALU_OP_ADD   = 2'b00;
    localparam logic [1:0] ALU_OP_SUB   = 2'b01;
    localparam logic [1:0] ALU_OP_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_B       = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef struct packed {
        logic       pc_en;
        logic       iord;
        logic       mem_write;
        logic       ir_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_src;
        logic       illegal_op;
    } ctrl_t;

    function automatic logic is_supported(input logic [OPCODE_W-1:0] op);
        return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
               (op == OP_BEQ)   || (op == OP_ADDI) || (op == OP_J);
    endfunction

endpackage

// File: rtl/mips_ctrl_decode.sv
// Combinational state -> control vector decode. Reset masks every architectural write
// strobe so an interrupted instruction cannot commit anything.
module mips_ctrl_decode
    import mips_ctrl_pkg::*;
(
    input  state_t                state,
    input  logic [OPCODE_W-1:0]   opcode,
    input  logic                  zero,
    input  logic                  reset,
    output ctrl_t                 ctrl
);

    always_comb begin
        ctrl = '0;
        case (state)
            S_FETCH: begin
                ctrl.ir_write  = 1'b1;
                ctrl.pc_en     = 1'b1;
                ctrl.alu_src_b = SRCB_FOUR;
                ctrl.alu_op    = ALU_OP_ADD;
                ctrl.pc_src    = PCSRC_ALU;
            end
            S_DECODE: begin
                // ALUOut gets the branch target here so BRANCH can use it directly.
                ctrl.alu_src_b  = SRCB_IMM_SH2;
                ctrl.alu_op     = ALU_OP_ADD;
                ctrl.illegal_op = !is_supported(opcode);
            end
            S_MEMADR: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALU_OP_ADD;
            end
            S_MEMRD: begin
                ctrl.iord = 1'b1;
            end
            S_MEMWB: begin
                ctrl.mem_to_reg = 1'b1;
                ctrl.reg_write  = 1'b1;
            end
            S_MEMWR: begin
                ctrl.iord      = 1'b1;
                ctrl.mem_write = 1'b1;
            end
            S_EXEC: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_B;
                ctrl.alu_op    = ALU_OP_FUNCT;
            end
            S_ALUWB: begin
                ctrl.reg_dst   = 1'b1;
                ctrl.reg_write = 1'b1;
            end
            S_BRANCH: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_B;
                ctrl.alu_op    = ALU_OP_SUB;
                ctrl.pc_src    = PCSRC_ALUOUT;
                ctrl.pc_en     = zero;
            end
            S_ADDIEX: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALU_OP_ADD;
            end
            S_ADDIWB: begin
                ctrl.reg_write = 1'b1;
            end
            S_JUMP: begin
                ctrl.pc_src = PCSRC_JUMP;
                ctrl.pc_en  = 1'b1;
            end
            default: ctrl = '0;
        endcase

        if (reset) begin
            ctrl.pc_en      = 1'b0;
            ctrl.ir_write   = 1'b0;
            ctrl.mem_write  = 1'b0;
            ctrl.reg_write  = 1'b0;
            ctrl.illegal_op = 1'b0;
        end
    end

endmodule

// File: rtl/mips_multi_control.sv
// Multicycle MIPS main control: state register and next-state sequencing; output decode
// lives in mips_ctrl_decode.
module mips_multi_control
    import mips_ctrl_pkg::*;
#(
    parameter int OP_W = 6,
    parameter int ST_W = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [OP_W-1:0] opcode,
    input  logic            zero,
    output logic            pc_en,
    output logic            iord,
    output logic            mem_write,
    output logic            ir_write,
    output logic            reg_dst,
    output logic            mem_to_reg,
    output logic            reg_write,
    output logic            alu_src_a,
    output logic [1:0]      alu_src_b,
    output logic [1:0]      alu_op,
    output logic [1:0]      pc_src,
    output logic            illegal_op,
    output logic [ST_W-1:0] state
);

    state_t state_q;
    state_t state_d;
    ctrl_t  ctrl;

    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_EXEC;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_ADDI:      state_d = S_ADDIEX;
                    OP_J:         state_d = S_JUMP;
                    default:      state_d = S_FETCH;
                endcase
            end
            S_MEMADR: state_d = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:  state_d = S_MEMWB;
            S_EXEC:   state_d = S_ALUWB;
            S_ADDIEX: state_d = S_ADDIWB;
            default:  state_d = S_FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    mips_ctrl_decode u_decode (
        .state  (state_q),
        .opcode (opcode),
        .zero   (zero),
        .reset  (reset),
        .ctrl   (ctrl)
    );

    assign pc_en      = ctrl.pc_en;
    assign iord       = ctrl.iord;
    assign mem_write  = ctrl.mem_write;
    assign ir_write   = ctrl.ir_write;
    assign reg_dst    = ctrl.reg_dst;
    assign mem_to_reg = ctrl.mem_to_reg;
    assign reg_write  = ctrl.reg_write;
    assign alu_src_a  = ctrl.alu_src_a;
    assign alu_src_b  = ctrl.alu_src_b;
    assign alu_op     = ctrl.alu_op;
    assign pc_src     = ctrl.pc_src;
    assign illegal_op = ctrl.illegal_op;
    assign state      = ST_W'(state_q);

endmodule

// File: tb/tb_mips_multi_control.sv
// Self-checking bench for mips_multi_control: per-instruction state walks and control
// values compared against a table-driven reference of the instruction set.
module tb_mips_multi_control;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [5:0] opcode = 6'b000000;
    logic       zero = 1'b0;
    logic       pc_en, iord, mem_write, ir_write, reg_dst, mem_to_reg, reg_write;
    logic       alu_src_a, illegal_op;
    logic [1:0] alu_src_b, alu_op, pc_src;
    logic [3:0] state;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mips_multi_control #(.OP_W(6), .ST_W(4)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .zero(zero),
        .pc_en(pc_en), .iord(iord), .mem_write(mem_write), .ir_write(ir_write),
        .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
        .pc_src(pc_src), .illegal_op(illegal_op), .state(state)
    );

    // Observed control vector:
    // {pc_en,iord,mem_write,ir_write,reg_dst,mem_to_reg,reg_write,src_a,src_b,alu_op,pc_src,illegal}
    function automatic logic [14:0] observed();
        return {pc_en, iord, mem_write, ir_write, reg_dst, mem_to_reg, reg_write,
                alu_src_a, alu_src_b, alu_op, pc_src, illegal_op};
    endfunction

    function automatic bit legal(input logic [5:0] op);
        return op == 6'b000000 || op == 6'b100011 || op == 6'b101011 ||
               op == 6'b000100 || op == 6'b001000 || op == 6'b000010;
    endfunction

    // Reference: the per-state output table of the instruction-set description.
    function automatic logic [14:0] expected(input int s, input bit z,
                                             input logic [5:0] op, input bit rst);
        bit pe = 0, io = 0, mw = 0, iw = 0, rd = 0, m2r = 0, rw = 0, sa = 0, ill = 0;
        logic [1:0] sb = 2'b00, ao = 2'b00, ps = 2'b00;
        case (s)
            0:  begin iw = 1; pe = 1; sb = 2'b01; end
            1:  begin sb = 2'b11; ill = !legal(op); end
            2:  begin sa = 1; sb = 2'b10; end
            3:  io = 1;
            4:  begin m2r = 1; rw = 1; end
            5:  begin io = 1; mw = 1; end
            6:  begin sa = 1; ao = 2'b10; end
            7:  begin rd = 1; rw = 1; end
            8:  begin sa = 1; ao = 2'b01; ps = 2'b01; pe = z; end
            9:  begin sa = 1; sb = 2'b10; end
            10: rw = 1;
            11: begin ps = 2'b10; pe = 1; end
            default: ;
        endcase
        if (rst) begin pe = 0; iw = 0; mw = 0; rw = 0; ill = 0; end
        return {pe, io, mw, iw, rd, m2r, rw, sa, sb, ao, ps, ill};
    endfunction

    // Expected state walk of one instruction, FETCH inclusive.
    function automatic void build_path(input logic [5:0] op, output int p[$]);
        p = {0, 1};
        case (op)
            6'b100011: p = {p, 2, 3, 4};
            6'b101011: p = {p, 2, 5};
            6'b000000: p = {p, 6, 7};
            6'b000100: p = {p, 8};
            6'b001000: p = {p, 9, 10};
            6'b000010: p = {p, 11};
            default: ;
        endcase
    endfunction

    // Runs one instruction starting in FETCH. If rst_at >= 0, reset is raised in that
    // step of the walk; the write strobes must be masked and FETCH must follow.
    task automatic run_instr(input string name, input logic [5:0] op, input bit z,
                             input int rst_at);
        int p[$];
        logic [14:0] exp_v;
        build_path(op, p);
        for (int i = 0; i < p.size(); i++) begin
            opcode = op;
            zero   = z;
            if (i == rst_at) reset = 1'b1;
            #1;
            exp_v = expected(p[i], z, op, reset);
            checks++;
            if (state !== 4'(p[i])) begin
                errors++;
                $display("FAIL %s step%0d state: got %0d want %0d", name, i, state, p[i]);
            end
            checks++;
            if (observed() !== exp_v) begin
                errors++;
                $display("FAIL %s step%0d ctrl: got %b want %b", name, i, observed(), exp_v);
            end
            checks++;
            if (reg_write === 1'b1 && mem_write === 1'b1) begin
                errors++;
                $display("FAIL %s step%0d write_exclusive: got rw=1 mw=1 want at most one", name, i);
            end
            @(posedge clk);
            #1;
            if (i == rst_at) begin
                reset = 1'b0;
                break;
            end
        end
    endtask

    task automatic check_fetch(input string name);
        #1;
        checks++;
        if (state !== 4'd0 || ir_write !== 1'b1 || pc_en !== 1'b1) begin
            errors++;
            $display("FAIL %s fetch: got state=%0d ir_write=%b pc_en=%b want 0 1 1",
                     name, state, ir_write, pc_en);
        end
    endtask

    task automatic test_reset();
        reset  = 1'b1;
        opcode = 6'b000000;
        for (int c = 0; c < 2; c++) begin
            @(posedge clk);
            #1;
            checks++;
            if (state !== 4'd0 || observed() !== expected(0, 0, 6'b000000, 1)) begin
                errors++;
                $display("FAIL reset cyc%0d: got state=%0d ctrl=%b want 0 %b",
                         c, state, observed(), expected(0, 0, 6'b000000, 1));
            end
        end
        reset = 1'b0;
        check_fetch("reset_release");
    endtask

    task automatic test_lw();      run_instr("lw", 6'b100011, 1'b0, -1);    endtask
    task automatic test_sw();      run_instr("sw", 6'b101011, 1'b1, -1);    endtask
    task automatic test_rtype();   run_instr("rtype", 6'b000000, 1'b0, -1); endtask
    task automatic test_addi();    run_instr("addi", 6'b001000, 1'b0, -1);  endtask
    task automatic test_jump();    run_instr("j", 6'b000010, 1'b0, -1);     endtask

    task automatic test_beq();
        run_instr("beq_taken", 6'b000100, 1'b1, -1);
        run_instr("beq_not_taken", 6'b000100, 1'b0, -1);
    endtask

    task automatic test_illegal();
        run_instr("illegal_3f", 6'b111111, 1'b0, -1);
        run_instr("illegal_01", 6'b000001, 1'b1, -1);
    endtask

    task automatic test_reset_mid();
        run_instr("reset_aluwb", 6'b000000, 1'b0, 3);
        check_fetch("after_reset_aluwb");
        run_instr("reset_memwb", 6'b100011, 1'b0, 4);
        check_fetch("after_reset_memwb");
        run_instr("reset_memwr", 6'b101011, 1'b0, 3);
        check_fetch("after_reset_memwr");
    endtask

    task automatic test_random();
        logic [5:0] legal_ops [6] = '{6'b000000, 6'b100011, 6'b101011,
                                      6'b000100, 6'b001000, 6'b000010};
        logic [5:0] op;
        for (int n = 0; n < 60; n++) begin
            if ($urandom_range(0, 3) == 0) op = 6'($urandom);
            else                           op = legal_ops[$urandom_range(0, 5)];
            run_instr("random", op, 1'($urandom), -1);
        end
    endtask

    task automatic test_back_to_back();
        run_instr("b2b_j", 6'b000010, 1'b0, -1);
        run_instr("b2b_illegal", 6'b101010, 1'b0, -1);
        run_instr("b2b_lw", 6'b100011, 1'b1, -1);
        check_fetch("b2b_end");
    endtask

    initial begin
        test_reset();
        test_lw();
        test_sw();
        test_rtype();
        test_addi();
        test_jump();
        test_beq();
        test_illegal();
        test_reset_mid();
        test_random();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
